// File: rtl/int_pkg.sv
// int_pkg: shared sizes, gateway state encoding and the "no interrupt" ID.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package int_pkg;

  localparam int INT_NSRC = 8;                      // default number of sources
  localparam int INT_PW   = 3;                      // default priority width
  localparam int INT_IDW  = $clog2(INT_NSRC + 1);   // default claim ID width

  // ID 0 is reserved for "nothing to claim".
  localparam int ID_NONE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } gw_state_t;

endpackage

// File: rtl/int_gateway.sv
// int_gateway: per-source request latch, IDLE -> PEND -> SERV -> IDLE.
// Latency: request to PEND in 1 cycle; claim/complete take effect at the next edge.
// Backpressure: none; requests arriving while SERV are ignored (level) or held one-deep (edge).
//
// Ports: clk, rstn (async, active-low); irq = raw request; claim/cmpl = already
// qualified for this source; edge_mode (only with INT_EDGE_TRIG_EN) selects
// rising-edge capture; pend/serv expose the current state.
module int_gateway
  import int_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic irq,
  input  logic claim,
  input  logic cmpl,
`ifdef INT_EDGE_TRIG_EN
  input  logic edge_mode,
`endif
  output logic pend,
  output logic serv
);

  gw_state_t state_q, state_d;
  logic      arm;       // request that moves IDLE -> PEND
  logic      relaunch;  // complete should go straight back to PEND

`ifdef INT_EDGE_TRIG_EN
  logic irq_q;
  logic rise;
  logic edge_held_q, edge_held_d;

  assign rise     = irq & ~irq_q;
  assign arm      = edge_mode ? rise : irq;
  // An edge landing in the very cycle of the complete is not lost.
  assign relaunch = edge_held_q | (edge_mode & rise);

  always_comb begin
    edge_held_d = edge_held_q;
    if (state_q == SERV) begin
      if (cmpl) begin
        edge_held_d = 1'b0;
      end else if (edge_mode && rise) begin
        edge_held_d = 1'b1;           // one-deep: further edges collapse into this one
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q       <= 1'b0;
      edge_held_q <= 1'b0;
    end else begin
      irq_q       <= irq;
      edge_held_q <= edge_held_d;
    end
  end
`else
  assign arm      = irq;
  assign relaunch = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm)   state_d = PEND;
      PEND:    if (claim) state_d = SERV;
      SERV:    if (cmpl)  state_d = relaunch ? PEND : IDLE;
      default:            state_d = IDLE;
    endcase
  end

  assign pend = (state_q == PEND);
  assign serv = (state_q == SERV);

endmodule

// File: rtl/int_claim_ctrl.sv
// int_claim_ctrl: gateways + registered max-priority arbiter driving one hart's eip.
// Latency: irq_src -> eip 2 cycles; config change -> best_id/eip 1 cycle; claim data next edge.
// Backpressure: none; a claim with nothing eligible returns 0, invalid completes are dropped.
//
// Ports: clk, rstn (async, active-low); irq_src/int_en/int_prio/threshold = source
// requests and configuration; reg_en/reg_wr/sel/reg_wdata = claim (read) and
// complete (write) access; reg_rdata = claimed ID; eip = interrupt to hart;
// busy = in-service flags. Optional macro INT_EDGE_TRIG_EN adds int_edge
// (1 = edge-triggered source).
module int_claim_ctrl
  import int_pkg::*;
#(
  parameter int NSRC = INT_NSRC,
  parameter int PW   = INT_PW,
  parameter int IDW  = $clog2(NSRC + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NSRC-1:0]    irq_src,
`ifdef INT_EDGE_TRIG_EN
  input  logic [NSRC-1:0]    int_edge,
`endif
  input  logic [NSRC-1:0]    int_en,
  input  logic [NSRC*PW-1:0] int_prio,
  input  logic [PW-1:0]      threshold,
  input  logic               reg_en,
  input  logic               reg_wr,
  input  logic               sel,
  input  logic [63:0]        reg_wdata,
  output logic [63:0]        reg_rdata,
  output logic               eip,
  output logic [NSRC-1:0]    busy
);

  logic [NSRC-1:0] pend, serv, elig, best_oh, claim_hit, cmpl_hit;
  logic [PW-1:0]   prio [NSRC];
  logic [IDW-1:0]  best_id, nxt_id, cmpl_id;
  logic [PW-1:0]   best_prio, nxt_prio;
  logic            claim_vld, cmpl_vld, best_ok, eip_q;
  logic [63:0]     rdata_q;

  assign claim_vld = reg_en & sel & ~reg_wr;
  assign cmpl_vld  = reg_en & sel &  reg_wr;
  assign cmpl_id   = reg_wdata[IDW-1:0];

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign prio[g]     = int_prio[g*PW +: PW];
    assign elig[g]     = pend[g] & int_en[g] & (prio[g] > threshold);
    assign best_oh[g]  = (best_id == IDW'(g + 1));
    // The claim only lands if the registered winner is still eligible right now.
    assign claim_hit[g] = claim_vld & best_oh[g] & elig[g];
    // Out-of-range and zero IDs match no source and fall through.
    assign cmpl_hit[g]  = cmpl_vld & (cmpl_id == IDW'(g + 1));

    int_gateway u_gw (
      .clk       (clk),
      .rstn      (rstn),
      .irq       (irq_src[g]),
      .claim     (claim_hit[g]),
      .cmpl      (cmpl_hit[g]),
`ifdef INT_EDGE_TRIG_EN
      .edge_mode (int_edge[g]),
`endif
      .pend      (pend[g]),
      .serv      (serv[g])
    );
  end

  // Strictly-greater compare while scanning upward keeps the lowest ID on a tie.
  always_comb begin
    nxt_id   = IDW'(ID_NONE);
    nxt_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (elig[i] && (prio[i] > nxt_prio)) begin
        nxt_id   = IDW'(i + 1);
        nxt_prio = prio[i];
      end
    end
  end

  // best_prio is zero exactly when the slot is empty.
  assign best_ok = (best_prio != '0) & (|(best_oh & elig));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      best_id   <= IDW'(ID_NONE);
      best_prio <= '0;
      eip_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      best_id   <= nxt_id;
      best_prio <= nxt_prio;
      // Registered alongside best_id so eip always mirrors best_id != 0.
      eip_q     <= (nxt_id != IDW'(ID_NONE));
      if (claim_vld) begin
        rdata_q <= best_ok ? {{(64-IDW){1'b0}}, best_id} : '0;
      end
    end
  end

  assign reg_rdata = rdata_q;
  assign eip       = eip_q;
  assign busy      = serv;

endmodule

// File: tb/tb_int_claim_ctrl.sv
// tb_int_claim_ctrl: directed plus randomized stimulus against a behavioural model.
// Latency: model tracks per-edge source states, the registered winner and claim data.
// Backpressure: n/a.
module tb_int_claim_ctrl;

  localparam int N    = 8;
  localparam int P    = 3;
  localparam int W    = 4;
  localparam int PWID = N * P;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    irq_src, int_en, int_edge;
  logic [PWID-1:0] int_prio;
  logic [P-1:0]    threshold;
  logic            reg_en, reg_wr, sel;
  logic [63:0]     reg_wdata, reg_rdata;
  logic            eip;
  logic [N-1:0]    busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_claim_ctrl #(.NSRC(N), .PW(P)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .irq_src   (irq_src),
`ifdef INT_EDGE_TRIG_EN
    .int_edge  (int_edge),
`endif
    .int_en    (int_en),
    .int_prio  (int_prio),
    .threshold (threshold),
    .reg_en    (reg_en),
    .reg_wr    (reg_wr),
    .sel       (sel),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .eip       (eip),
    .busy      (busy)
  );

  // Model: per source 0 = waiting, 1 = pending, 2 = in service.
  int          m_st   [N];
  bit          m_held [N];
  bit          m_prev [N];
  int          m_best;
  bit          m_eip;
  logic [63:0] m_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pr(int i);
    return int'(int_prio[i*P +: P]);
  endfunction

  function automatic bit elig(int i);
    return (m_st[i] == 1) && int_en[i] && (pr(i) > int'(threshold));
  endfunction

  function automatic logic [N-1:0] m_busy();
    logic [N-1:0] b = '0;
    for (int i = 0; i < N; i++) b[i] = (m_st[i] == 2);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_held[i] = 0; m_prev[i] = 0;
    end
    m_best = 0; m_eip = 0; m_rdata = '0;
  endtask

  task automatic cmp_outputs(input string pfx);
    chk({pfx, "_eip"}, eip, m_eip);
    chk({pfx, "_rdata"}, reg_rdata, m_rdata);
    chk({pfx, "_busy"}, busy, m_busy());
  endtask

  // Advance one clock: predict from the inputs applied now, then compare.
  task automatic tick();
    int ns [N];
    bit nh [N];
    bit done [N];
    int nb, bs, sc, cid;
    bit rise;
    logic [63:0] nr;
    nb = 0; bs = -1; nr = m_rdata;
    for (int i = 0; i < N; i++) begin
      ns[i] = m_st[i]; nh[i] = m_held[i]; done[i] = 0;
    end
    // Winner: highest priority, lower ID wins ties (encoded into one score).
    for (int i = 0; i < N; i++) begin
      if (elig(i)) begin
        sc = pr(i) * (N + 1) + (N - i);
        if (sc > bs) begin bs = sc; nb = i + 1; end
      end
    end
    if (reg_en && sel && !reg_wr) begin
      if (m_best != 0 && elig(m_best - 1)) begin
        nr = 64'(m_best); ns[m_best-1] = 2;
      end else begin
        nr = '0;
      end
    end
    if (reg_en && sel && reg_wr) begin
      cid = int'(reg_wdata[W-1:0]);
      if (cid >= 1 && cid <= N && m_st[cid-1] == 2) begin
        rise = irq_src[cid-1] && !m_prev[cid-1];
        ns[cid-1]   = (m_held[cid-1] || (int_edge[cid-1] && rise)) ? 1 : 0;
        nh[cid-1]   = 0;
        done[cid-1] = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      rise = irq_src[i] && !m_prev[i];
      if (m_st[i] == 0 && (int_edge[i] ? rise : irq_src[i])) ns[i] = 1;
      if (m_st[i] == 2 && int_edge[i] && rise && !done[i]) nh[i] = 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      m_st[i] = ns[i]; m_held[i] = nh[i]; m_prev[i] = irq_src[i];
    end
    m_best = nb; m_eip = (nb != 0); m_rdata = nr;
    cmp_outputs("cyc");
  endtask

  task automatic bus_idle();
    reg_en = 0; reg_wr = 0; sel = 0; reg_wdata = '0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_claim();
    reg_en = 1; sel = 1; reg_wr = 0;
    tick();
    bus_idle();
  endtask

  task automatic do_cmpl(input int id);
    reg_en = 1; sel = 1; reg_wr = 1;
    reg_wdata = {$urandom, $urandom};
    reg_wdata[W-1:0] = W'(id);
    tick();
    bus_idle();
  endtask

  task automatic set_prio(input int i, input int p);
    int_prio[i*P +: P] = P'(p);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_src = irq_src | m;
    tick();
    irq_src = irq_src & ~m;
  endtask

  task automatic mid_reset(input string tag);
    rstn = 0;
    #1;
    model_reset();
    chk({tag, "_busy"}, busy, '0);
    chk({tag, "_eip"}, eip, 1'b0);
    chk({tag, "_rdata"}, reg_rdata, '0);
    #1 rstn = 1;
  endtask

  initial begin
    rstn = 0; irq_src = '0; int_en = '1; int_edge = '0; int_prio = '0;
    threshold = '0;
    bus_idle();
    model_reset();
    #12;
    cmp_outputs("reset");
    rstn = 1;

    // Single source: two-cycle latency, claim, eip drop, level re-arm.
    set_prio(2, 5);
    irq_src[2] = 1;
    tick();
    chk("t1_eip_early", eip, 1'b0);
    tick();
    chk("t1_eip_lat", eip, 1'b1);
    do_claim();
    chk("t1_claim", reg_rdata, 64'd3);
    chk("t1_busy", busy, 8'h04);
    tick();
    chk("t1_eip_drop", eip, 1'b0);
    do_cmpl(3);
    wait_n(2);
    do_claim();
    chk("t4_rearm_claim", reg_rdata, 64'd3);
    irq_src[2] = 0;
    do_cmpl(0);
    do_cmpl(9);
    do_cmpl(5);
    chk("t4_bad_cmpl", busy, 8'h04);
    do_cmpl(3);
    chk("t4_cmpl", busy, 8'h00);
    wait_n(2);

    // Tie goes to the lower ID; higher priority wins otherwise.
    int_prio = '0; set_prio(1, 4); set_prio(4, 4);
    pulse(8'h12);
    wait_n(1);
    do_claim();
    chk("t2_tie_first", reg_rdata, 64'd2);
    wait_n(1);
    do_claim();
    chk("t2_tie_second", reg_rdata, 64'd5);
    do_cmpl(2); do_cmpl(5);
    set_prio(4, 6);
    pulse(8'h12);
    wait_n(1);
    do_claim();
    chk("t2_hi_prio", reg_rdata, 64'd5);
    wait_n(1);
    do_claim();
    do_cmpl(2); do_cmpl(5);
    wait_n(2);

    // Threshold is exclusive.
    int_prio = '0; set_prio(0, 4); threshold = 3'd4;
    pulse(8'h01);
    wait_n(2);
    chk("t3_eip_thr", eip, 1'b0);
    do_claim();
    chk("t3_claim_thr", reg_rdata, 64'd0);
    threshold = 3'd3;
    wait_n(2);
    chk("t3_eip_lowered", eip, 1'b1);
    do_claim();
    chk("t3_claim_lowered", reg_rdata, 64'd1);
    do_cmpl(1);
    threshold = '0;
    wait_n(2);

    // Enable dropped under a registered winner: claim misses, source stays pending.
    int_prio = '0; set_prio(3, 2);
    pulse(8'h08);
    wait_n(1);
    int_en[3] = 0;
    do_claim();
    chk("t5_claim_dis", reg_rdata, 64'd0);
    chk("t5_busy_dis", busy, 8'h00);
    int_en = '1;
    wait_n(1);
    do_claim();
    chk("t5_claim_reen", reg_rdata, 64'd4);
    do_cmpl(4);
    wait_n(2);

`ifdef INT_EDGE_TRIG_EN
    int_prio = '0; set_prio(0, 3); int_edge = 8'h01;
    pulse(8'h01);
    wait_n(1);
    do_claim();
    chk("e_claim", reg_rdata, 64'd1);
    pulse(8'h01); tick();
    pulse(8'h01); tick();
    do_cmpl(1);
    chk("e_cmpl_busy", busy, 8'h00);
    tick();
    chk("e_repend_eip", eip, 1'b1);
    do_claim();
    chk("e_claim_held", reg_rdata, 64'd1);
    do_cmpl(1);
    wait_n(3);
    chk("e_eip_quiet", eip, 1'b0);
    do_claim();
    chk("e_claim_none", reg_rdata, 64'd0);
`endif

    // Reset in the middle of service.
    int_prio = '0; set_prio(0, 3);
    pulse(8'h01);
    wait_n(1);
    do_claim();
    chk("r_claim", reg_rdata, 64'd1);
    mid_reset("r_mid");
    wait_n(2);

    // Randomized phase.
`ifdef INT_EDGE_TRIG_EN
    int_edge = N'($urandom);
`endif
    int_prio = PWID'($urandom);
    for (int c = 0; c < 1500; c++) begin
      int k, sel_op;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, N - 1);
        irq_src[k] = ~irq_src[k];
      end
      if ($urandom_range(0, 31) == 0) int_en = N'($urandom);
      if ($urandom_range(0, 31) == 0) int_prio = PWID'($urandom);
      if ($urandom_range(0, 63) == 0) threshold = P'($urandom_range(0, 3));
      bus_idle();
      sel_op = $urandom_range(0, 9);
      if (sel_op <= 3) begin
        reg_en = 1; reg_wr = (sel_op >= 2); sel = ($urandom_range(0, 7) != 0);
        reg_wdata = {$urandom, $urandom};
        if (sel_op == 3) begin
          k = $urandom_range(0, N - 1);
          for (int j = 0; j < N; j++) begin
            if (m_st[(k + j) % N] == 2) begin
              reg_wdata[W-1:0] = W'(((k + j) % N) + 1);
              break;
            end
          end
        end
      end
      tick();
      if (c == 700) mid_reset("rnd_reset");
    end
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
